peridot_dualboot_responder: RTL and testbench

//  Avalon-MM responder that models the MAX 10 dual-boot register block behind a 3-bit address map.
//  - Stands in for the vendor dual-boot IP on non-MAX 10 families and in simulation.
//  - Remote-update sequencers can then run unchanged.
//  - Reports which image is loaded through a status snapshot.
//  - Turns a reconfig-trigger write into a delayed reconfig_req pulse plus target-image select.

---
 rtl/peridot_dualboot_pkg.sv | 37 +++
 rtl/peridot_dualboot_responder.sv | 138 +++++++++++++
 tb/tb_peridot_dualboot_responder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peridot_dualboot_pkg.sv
// Shared definitions for the dual-boot register block stand-in:
// register map, controller states and remote-system-upgrade status codes.
package peridot_dualboot_pkg;

  // Register map (3-bit word address)
  localparam logic [2:0] ADDR_TRIGGER   = 3'd0;  // W: bit0=1 starts reconfiguration
  localparam logic [2:0] ADDR_OVERWRITE = 3'd1;  // W: bit0 overwrite_en, bit1 overwrite_sel
  localparam logic [2:0] ADDR_SNAP_REQ  = 3'd2;  // W: bit0=1 requests a status snapshot
  localparam logic [2:0] ADDR_STATUS    = 3'd3;  // R: bit0 busy
  localparam logic [2:0] ADDR_SNAPSHOT  = 3'd4;  // R: msm_cs field

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNAP   = 2'd1,
    ST_RECONF = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  // Master state machine current-state codes as the vendor block reports them
  localparam logic [3:0] MSM_CS_IMAGE0 = 4'b0101;
  localparam logic [3:0] MSM_CS_IMAGE1 = 4'b0011;

  // Position of the 4-bit msm_cs field inside the snapshot read word
  localparam int unsigned SNAP_LSB = 13;

  // A zero-cycle delay is treated as a one-cycle delay
  function automatic int unsigned eff_cycles(input int unsigned cycles);
    return (cycles == 0) ? 1 : cycles;
  endfunction

  // Status code for the image that is currently running
  function automatic logic [3:0] msm_cs_for(input logic image);
    return image ? MSM_CS_IMAGE1 : MSM_CS_IMAGE0;
  endfunction

endpackage

// File: rtl/peridot_dualboot_responder.sv
// Avalon-MM responder emulating the MAX 10 dual-boot register block.
// Status snapshots report the running image; a trigger write produces a
// delayed one-cycle reconfig_req together with the selected target image.
module peridot_dualboot_responder
  import peridot_dualboot_pkg::*;
#(
  parameter int unsigned CONFIG_CYCLE      = 28,
  parameter int unsigned RESET_TIMER_CYCLE = 40
) (
  input  logic        clock_sig,
  input  logic        reset_sig,
  input  logic        nreset,
  input  logic [2:0]  avmm_address,
  input  logic        avmm_write,
  input  logic [31:0] avmm_writedata,
  input  logic        avmm_read,
  output logic [31:0] avmm_readdata,
  input  logic        boot_image,
  input  logic        config_sel_pin,
  output logic        reconfig_req,
  output logic        reconfig_image
);

  localparam int unsigned CFG_EFF = eff_cycles(CONFIG_CYCLE);
  localparam int unsigned RST_EFF = eff_cycles(RESET_TIMER_CYCLE);
  localparam int unsigned MAX_EFF = (CFG_EFF > RST_EFF) ? CFG_EFF : RST_EFF;
  localparam int unsigned TW      = $clog2(MAX_EFF) + 1;

  localparam logic [TW-1:0] CFG_LOAD = TW'(CFG_EFF - 1);
  localparam logic [TW-1:0] RST_LOAD = TW'(RST_EFF - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          ow_en_q;
  logic          ow_sel_q;
  logic [3:0]    snap_q;
  logic          req_q;
  logic          image_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rdata_d;

  logic wr_trigger;
  logic wr_overwrite;
  logic wr_snap_req;

  // Only bits [1:0] of the write data carry meaning
  logic wdata_unused;
  assign wdata_unused = ^avmm_writedata[31:2];

  assign wr_trigger   = avmm_write && (avmm_address == ADDR_TRIGGER)   && avmm_writedata[0];
  assign wr_overwrite = avmm_write && (avmm_address == ADDR_OVERWRITE);
  assign wr_snap_req  = avmm_write && (avmm_address == ADDR_SNAP_REQ)  && avmm_writedata[0];

  // Controller: accepts commands only in IDLE, runs snapshot / reconfig timers
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      ow_en_q  <= 1'b0;
      ow_sel_q <= 1'b0;
      snap_q   <= '0;
      req_q    <= 1'b0;
      image_q  <= 1'b0;
    end else if (!nreset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      ow_en_q  <= 1'b0;
      ow_sel_q <= 1'b0;
      snap_q   <= '0;
      req_q    <= 1'b0;
      image_q  <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_snap_req) begin
            state_q <= ST_SNAP;
            timer_q <= CFG_LOAD;
          end else if (wr_trigger) begin
            state_q <= ST_RECONF;
            timer_q <= RST_LOAD;
          end else if (wr_overwrite) begin
            ow_en_q  <= avmm_writedata[0];
            ow_sel_q <= avmm_writedata[1];
          end
        end
        ST_SNAP: begin
          if (timer_q == '0) begin
            snap_q  <= msm_cs_for(boot_image);
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end
        ST_RECONF: begin
          if (timer_q == '0) begin
            req_q   <= 1'b1;
            image_q <= ow_en_q ? ow_sel_q : config_sel_pin;
            state_q <= ST_HALT;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end
        ST_HALT: begin
          // Terminal: only a reset leaves this state
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read decode from the current (pre-write) register state
  always_comb begin
    rdata_d = '0;
    case (avmm_address)
      ADDR_STATUS:   rdata_d[0] = (state_q != ST_IDLE);
      ADDR_SNAPSHOT: rdata_d[SNAP_LSB +: 4] = snap_q;
      default:       rdata_d = '0;
    endcase
  end

  // Registered read data: updates on every read cycle, holds otherwise
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      rdata_q <= '0;
    end else if (!nreset) begin
      rdata_q <= '0;
    end else if (avmm_read) begin
      rdata_q <= rdata_d;
    end
  end

  assign avmm_readdata  = rdata_q;
  assign reconfig_req   = req_q;
  assign reconfig_image = image_q;

endmodule

// File: tb/tb_peridot_dualboot_responder.sv
// Self-checking bench for peridot_dualboot_responder: directed sequence with
// randomized data/images/gaps, checked against a cycle-window reference model.
module tb_peridot_dualboot_responder;

  localparam int unsigned CC  = 28;
  localparam int unsigned RTC = 40;
  localparam int NEVER = 32'h7fffffff;

  logic        clock_sig = 1'b0;
  logic        reset_sig = 1'b0;
  logic        nreset = 1'b1;
  logic [2:0]  avmm_address = '0;
  logic        avmm_write = 1'b0;
  logic [31:0] avmm_writedata = '0;
  logic        avmm_read = 1'b0;
  logic [31:0] avmm_readdata;
  logic        boot_image = 1'b0;
  logic        config_sel_pin = 1'b0;
  logic        reconfig_req;
  logic        reconfig_image;

  peridot_dualboot_responder #(
    .CONFIG_CYCLE     (CC),
    .RESET_TIMER_CYCLE(RTC)
  ) dut (
    .clock_sig     (clock_sig),
    .reset_sig     (reset_sig),
    .nreset        (nreset),
    .avmm_address  (avmm_address),
    .avmm_write    (avmm_write),
    .avmm_writedata(avmm_writedata),
    .avmm_read     (avmm_read),
    .avmm_readdata (avmm_readdata),
    .boot_image    (boot_image),
    .config_sel_pin(config_sel_pin),
    .reconfig_req  (reconfig_req),
    .reconfig_image(reconfig_image)
  );

  always #5 clock_sig = ~clock_sig;

  // Edge counter: after posedge N (sampled #1 later) cyc == N
  int cyc = 0;
  always @(posedge clock_sig) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int   at;
    logic img;
  } pulse_t;

  pulse_t got_q[$];
  pulse_t exp_q[$];

  always @(negedge clock_sig)
    if (reconfig_req === 1'b1) got_q.push_back('{cyc, reconfig_image});

  // ---------------- reference model ----------------
  // Busy/snapshot visibility expressed as windows of edge numbers: a read or
  // write sampled at edge e sees the responder as it was after edge e-1.
  int          busy_lo, busy_hi, halt_from;
  bit          halted;
  logic [31:0] snap_cur, snap_next;
  int          snap_from;
  bit          ow_en, ow_sel;
  logic [31:0] last_rd;

  function automatic bit m_busy(input int e);
    return (e >= busy_lo && e <= busy_hi) || (halted && e >= halt_from);
  endfunction

  function automatic logic [31:0] m_snap(input int e);
    return (e >= snap_from) ? snap_next : snap_cur;
  endfunction

  function automatic logic [31:0] m_read(input int e, input int a);
    if (nreset !== 1'b1) return 32'd0;
    case (a)
      3:       return {31'd0, m_busy(e)};
      4:       return m_snap(e);
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    busy_lo = 1; busy_hi = 0; halted = 0; halt_from = NEVER;
    snap_cur = 32'd0; snap_next = 32'd0; snap_from = NEVER;
    ow_en = 0; ow_sel = 0; last_rd = 32'd0;
    exp_q.delete();
  endtask

  task automatic m_write(input int w, input int a, input logic [31:0] d);
    if (nreset !== 1'b1) begin m_reset(); return; end
    if (m_busy(w)) return;
    case (a)
      0: if (d[0]) begin
           halted = 1; halt_from = w + 1;
           exp_q.push_back('{w + int'(RTC), ow_en ? ow_sel : config_sel_pin});
         end
      1: begin ow_en = d[0]; ow_sel = d[1]; end
      2: if (d[0]) begin
           snap_cur  = m_snap(w);
           snap_next = boot_image ? 32'h0000_6000 : 32'h0000_A000;
           snap_from = w + int'(CC) + 1;
           busy_lo = w + 1; busy_hi = w + int'(CC);
         end
      default: ;
    endcase
  endtask

  // ---------------- checking and bus tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock_sig); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avmm_address = a; avmm_writedata = d; avmm_write = 1'b1;
    @(posedge clock_sig); #1;
    avmm_write = 1'b0;
    m_write(cyc, int'(a), d);
  endtask

  task automatic rd(input string tag, input logic [2:0] a, output logic [31:0] v);
    avmm_address = a; avmm_read = 1'b1;
    @(posedge clock_sig); #1;
    avmm_read = 1'b0;
    v = avmm_readdata;
    last_rd = m_read(cyc, int'(a));
    chk(tag, v, last_rd);
  endtask

  task automatic rdwr(input string tag, input logic [2:0] a, input logic [31:0] d);
    avmm_address = a; avmm_writedata = d; avmm_write = 1'b1; avmm_read = 1'b1;
    @(posedge clock_sig); #1;
    avmm_write = 1'b0; avmm_read = 1'b0;
    last_rd = m_read(cyc, int'(a));
    chk(tag, avmm_readdata, last_rd);
    m_write(cyc, int'(a), d);
  endtask

  task automatic poll_idle(input string tag, input int exp_n);
    int n;
    logic [31:0] v;
    n = 0;
    do begin
      rd({tag, "_poll"}, 3'd3, v);
      n++;
    end while (v[0] !== 1'b0 && n < 200);
    chk({tag, "_polls"}, n, exp_n);
  endtask

  function automatic int remaining_polls();
    return (busy_hi >= cyc + 1) ? busy_hi + 1 - cyc : 1;
  endfunction

  task automatic check_pulses(input string tag);
    chk({tag, "_pulse_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_pulse_cycle"}, got_q[i].at, exp_q[i].at);
      chk({tag, "_pulse_image"}, got_q[i].img, exp_q[i].img);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic hard_reset();
    reset_sig = 1'b1;
    #1;
    chk("rst_readdata", avmm_readdata, 32'd0);
    chk("rst_req", reconfig_req, 32'd0);
    chk("rst_image", reconfig_image, 32'd0);
    m_reset();
    idle(2);
    reset_sig = 1'b0;
    idle(1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "simulation did not finish");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] v;
    m_reset();
    #1;
    hard_reset();

    // Snapshot register is empty before any snapshot; sweep the whole map
    rd("a4_pre", 3'd4, v);
    chk("a4_pre_zero", v, 32'd0);
    for (int a = 0; a < 8; a++) rd("sweep", 3'(a), v);

    // Snapshot for image1, image0, then random images
    for (int i = 0; i < 4; i++) begin
      boot_image = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      wr(3'd2, $urandom | 32'd1);
      poll_idle("snap", int'(CC) + 1);
      rd("snap_a4", 3'd4, v);
      chk("snap_a4_value", v, boot_image ? 32'h0000_6000 : 32'h0000_A000);
      chk("snap_decode", 32'(v[15] ^ v[13]), 32'(boot_image));
      idle(int'($urandom_range(1, 3)));
      chk("rd_hold", avmm_readdata, last_rd);
    end

    // Writes with bit0=0 do not start anything
    wr(3'd2, $urandom & ~32'd1);
    rd("snap_bit0_zero", 3'd3, v);
    wr(3'd0, $urandom & ~32'd1);
    rd("trig_bit0_zero", 3'd3, v);
    idle(int'(RTC) + 2);
    check_pulses("bit0_zero");

    // Read+write together returns pre-write data; commands during SNAP ignored
    boot_image = 1'($urandom_range(0, 1));
    rdwr("rdwr_a2", 3'd2, 32'd1);
    rd("busy_after_start", 3'd3, v);
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd3);
    poll_idle("snap_busy_cmds", remaining_polls());
    rd("snap_busy_a4", 3'd4, v);
    idle(int'(RTC) + 5);
    check_pulses("trig_in_snap");

    // Overwrite selects image1 despite CONFIG_SEL=0; HALT ignores everything
    config_sel_pin = 1'b0;
    wr(3'd1, 32'd3);
    wr(3'd0, 32'd1);
    rd("reconf_busy", 3'd3, v);
    idle(int'(RTC) + 5);
    check_pulses("ow_sel1");
    rd("halt_busy", 3'd3, v);
    chk("halt_busy_one", v, 32'd1);
    wr(3'd2, 32'd1);
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd0);
    rd("halt_a4", 3'd4, v);
    idle(int'(RTC) + 5);
    check_pulses("halt_writes");
    rd("halt_busy2", 3'd3, v);

    // Overwrite enabled with sel=0 beats CONFIG_SEL=1
    hard_reset();
    config_sel_pin = 1'b1;
    wr(3'd1, 32'd1);
    wr(3'd0, 32'd1);
    idle(int'(RTC) + 5);
    check_pulses("ow_sel0");

    // No overwrite: CONFIG_SEL=1 chooses image1
    hard_reset();
    config_sel_pin = 1'b1;
    wr(3'd0, 32'd1);
    idle(int'(RTC) + 5);
    check_pulses("pin_sel1");

    // Random overwrite settings, pin levels and gaps
    for (int i = 0; i < 3; i++) begin
      hard_reset();
      config_sel_pin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) wr(3'd1, $urandom);
      idle(int'($urandom_range(0, 4)));
      wr(3'd0, $urandom | 32'd1);
      idle(int'(RTC) + 5);
      check_pulses("rand_reconf");
    end

    // Reset in the middle of RECONF: no pulse, everything cleared
    hard_reset();
    boot_image = 1'($urandom_range(0, 1));
    wr(3'd2, 32'd1);
    poll_idle("pre_abort_snap", int'(CC) + 1);
    wr(3'd0, 32'd1);
    idle(int'($urandom_range(5, RTC - 5)));
    hard_reset();
    rd("abort_busy", 3'd3, v);
    chk("abort_busy_zero", v, 32'd0);
    rd("abort_a4", 3'd4, v);
    chk("abort_a4_zero", v, 32'd0);
    idle(int'(RTC) + 5);
    check_pulses("abort");

    // Soft reset held low: writes ignored, readdata forced to 0
    wr(3'd2, 32'd1);
    idle(3);
    nreset = 1'b0;
    m_reset();
    for (int i = 0; i < 6; i++) begin
      avmm_address = 3'($urandom_range(0, 4));
      avmm_writedata = $urandom | 32'd1;
      avmm_write = 1'b1;
      avmm_read = 1'b1;
      @(posedge clock_sig); #1;
      chk("nrst_readdata", avmm_readdata, 32'd0);
      chk("nrst_req", reconfig_req, 32'd0);
    end
    avmm_write = 1'b0;
    avmm_read = 1'b0;
    nreset = 1'b1;
    idle(1);
    rd("nrst_busy", 3'd3, v);
    rd("nrst_a4", 3'd4, v);
    boot_image = 1'($urandom_range(0, 1));
    wr(3'd2, 32'd1);
    poll_idle("nrst_snap", int'(CC) + 1);
    rd("nrst_snap_a4", 3'd4, v);
    chk("nrst_snap_value", v, boot_image ? 32'h0000_6000 : 32'h0000_A000);
    idle(int'(RTC) + 5);
    check_pulses("nrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
